int_add_seq: RTL and testbench
==============================

// Module: int_add_seq
// PURPOSE
//  Multi-cycle integer adder. Adds two WIDTH-bit operands one CHUNK-bit slice per cycle, LSB slice first.
//  A registered carry links the slices, so the logic depth is one CHUNK-bit add instead of a full-width
//  carry chain. Sits in the int ALU path as the low-area alternative to the single-cycle carry-select adder.
//  Takes operands from the issue stage through a req/ack handshake and hands the sum to writeback.
// PARAMETERS
//  WIDTH   32  operand and result width in bits
//  CHUNK   8   slice width added per cycle; WIDTH % CHUNK must be 0, else $error at elaboration
//  NCHUNK  WIDTH/CHUNK  localparam, number of BUSY cycles
// PORTS
//  clk    in   1      clock; all state updates on posedge
//  rst    in   1      reset, asynchronous, active-high
//  req    in   1      start request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand a; captured in the cycle req is accepted
//  b      in   WIDTH  operand b; captured in the cycle req is accepted
//  busy   out  1      high in BUSY
//  ack    out  1      one-cycle pulse, high in DONE; out/cout are valid
//  out    out  WIDTH  sum; holds its value until the next ack
//  cout   out  1      carry out of the MSB slice; holds with out
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, ack=0, out=0, cout=0; operand, carry and index registers cleared.
//  States
//   IDLE: req=1 -> load a/b into op regs, carry=cin (0), idx=0, go to BUSY; otherwise stay in IDLE.
//   BUSY: each cycle computes {c,s} = op_a[idx] + op_b[idx] + carry on one slice.
//         It writes s into result slice idx, sets carry=c and increments idx.
//         After slice NCHUNK-1: go to DONE, latch the result into out and the final carry into cout.
//   DONE: ack=1 for exactly this cycle. req=1 -> accept a new op as in IDLE and go to BUSY
//         (back-to-back); otherwise go to IDLE.
//  Latency: req accepted in cycle t -> BUSY in cycles t+1..t+NCHUNK -> ack in cycle t+NCHUNK+1.
//   Defaults give ack 5 cycles after req. Back-to-back throughput: one result every NCHUNK+1 cycles.
//  req in BUSY: ignored, with no queuing and no effect on the op in flight.
//  Arithmetic: modulo 2^WIDTH; the carry out of the MSB is reported on cout, never dropped.
//  out/cout change only on the DONE transition. They are stable through BUSY, so the previous result
//   stays readable.
//  rst asserted mid-operation: aborts at once, returns to IDLE with reset values, and no ack is produced.
//  CHUNK==WIDTH is legal: NCHUNK=1, ack 2 cycles after req.
// CONFIGURATION
//  INT_ADD_SEQ_SUB_EN defined: adds input port sub (1 bit), captured with a/b on req acceptance.
//   sub=1 -> op_b loaded as ~b and the initial carry=1, giving out = a - b.
//   cout=1 means no borrow (a >= b unsigned).
//  INT_ADD_SEQ_SUB_EN undefined: no sub port, the initial carry is always 0, add only.
// STRUCTURE
//  Package int_add_pkg: typedef enum logic[1:0] {IDLE, BUSY, DONE} int_add_state_e,
//   plus default WIDTH/CHUNK constants.
//  Sub-module chunk_add (combinational): CHUNK-bit a, b, cin -> CHUNK-bit sum, cout.
//   Instantiated once and driven by the slice selected by idx.
//  Top holds the FSM, the idx counter ($clog2(NCHUNK) bits, minimum 1), operand regs, result reg and carry reg.
// TESTING
//  1. a=32'hFFFF_FFFF, b=1, req 1 cycle -> busy high 4 cycles; ack in cycle t+5; out=0, cout=1.
//  2. a=32'h1234_5678, b=32'h1111_1111 -> out=32'h2345_6789, cout=0; out unchanged in the following IDLE cycles.
//  3. req held high continuously with operand pairs (1,2) then (3,4) -> acks 5 cycles apart.
//     out=3 then out=7; the second op is accepted in the DONE cycle of the first.
//  4. Second req pulse in the 2nd BUSY cycle with a=b=32'hAAAA_AAAA -> ignored; exactly one ack,
//     carrying the first op's result.
//  5. rst pulsed in the 3rd BUSY cycle -> busy=0, out=0, cout=0 at once; no ack for the next 10 cycles
//     without req.
//  6. SUB_EN: a=5, b=7, sub=1 -> out=32'hFFFF_FFFE, cout=0. a=7, b=5, sub=1 -> out=2, cout=1.

Source files
------------

// File: rtl/int_add_seq_pkg.sv
// rtl/int_add_seq_pkg.sv - shared types and defaults for the sequential integer adder
//
// Purpose : FSM state encoding and default operand/slice widths used by the
//           int_add_seq interface, top level and testbench.
// Ports   : none (package).
// Config  : INT_ADD_SEQ_SUB_EN (see rtl/int_add_seq.sv) needs nothing from here.

package int_add_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } int_add_state_e;

endpackage

// File: rtl/int_add_seq_if.sv
// rtl/int_add_seq_if.sv - request/response bundle between issue, adder and writeback
//
// Purpose : Groups the operand request (req, a, b [, sub]) and the result
//           response (busy, ack, out, cout) of int_add_seq.
// Ports   : none; modports
//             master - issue/writeback side: drives req/a/b[/sub], reads results
//             slave  - adder side: reads req/a/b[/sub], drives busy/ack/out/cout
// Config  : INT_ADD_SEQ_SUB_EN adds the 1-bit sub signal.

interface int_add_seq_if #(
    parameter int WIDTH = int_add_pkg::DEFAULT_WIDTH
);

    logic             req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef INT_ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             ack;
    logic [WIDTH-1:0] out;
    logic             cout;

`ifdef INT_ADD_SEQ_SUB_EN
    modport master (
        output req, a, b, sub,
        input  busy, ack, out, cout
    );

    modport slave (
        input  req, a, b, sub,
        output busy, ack, out, cout
    );
`else
    modport master (
        output req, a, b,
        input  busy, ack, out, cout
    );

    modport slave (
        input  req, a, b,
        output busy, ack, out, cout
    );
`endif

endinterface

// File: rtl/int_add_seq_chunk_add.sv
// rtl/int_add_seq_chunk_add.sv - combinational CHUNK-bit adder slice with carry in/out
//
// Purpose : One slice of the sequential adder: {cout, sum} = a + b + cin.
// Ports   : a    in  CHUNK  slice of operand a
//           b    in  CHUNK  slice of operand b
//           cin  in  1      carry from the previous slice
//           sum  out CHUNK  slice sum
//           cout out 1      carry into the next slice

module chunk_add #(
    parameter int CHUNK = int_add_pkg::DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // Widen by one bit so the carry out falls into the MSB of the result.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/int_add_seq.sv
// rtl/int_add_seq.sv - multi-cycle integer adder, one CHUNK-bit slice per cycle
//
// Purpose : Adds two WIDTH-bit operands LSB slice first, linking slices with a
//           registered carry so the logic depth is one CHUNK-bit add.
//           Latency: req accepted in cycle t, BUSY t+1..t+NCHUNK, ack in t+NCHUNK+1.
// Ports   : clk  in  1   clock, rising edge
//           rst  in  1   asynchronous active-high reset
//           bus  slave modport of int_add_seq_if:
//                  req/a/b[/sub] in, busy/ack/out/cout out
// Config  : INT_ADD_SEQ_SUB_EN defined -> bus.sub selects a - b (b inverted,
//           initial carry 1; cout=1 means no borrow). Undefined -> add only.

module int_add_seq
    import int_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic           clk,
    input  logic           rst,
    int_add_seq_if.slave   bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("int_add_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
        end
    endgenerate

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] out_q;
    logic             cout_q;

    // Operand b and initial carry as loaded on acceptance.
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef INT_ADD_SEQ_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_load   = bus.sub ? ~bus.b : bus.b;
    assign cin_load = bus.sub;
`else
    assign b_load   = bus.b;
    assign cin_load = 1'b0;
`endif

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    assign slice_a = op_a[idx * CHUNK +: CHUNK];
    assign slice_b = op_b[idx * CHUNK +: CHUNK];

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Result with the current slice merged in; on the last slice this is the
    // full sum, which lets out be loaded in the same cycle as res.
    logic [WIDTH-1:0] res_next;

    always_comb begin
        res_next = res;
        res_next[idx * CHUNK +: CHUNK] = slice_sum;
    end

    wire last_slice = (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            res    <= '0;
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new request just like IDLE so back-to-back
                // operations lose no cycle beyond the ack.
                S_IDLE, S_DONE: begin
                    if (bus.req) begin
                        op_a  <= bus.a;
                        op_b  <= b_load;
                        carry <= cin_load;
                        idx   <= '0;
                        state <= S_BUSY;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                // req is deliberately not looked at here: no queuing.
                S_BUSY: begin
                    res   <= res_next;
                    carry <= slice_cout;
                    if (last_slice) begin
                        out_q  <= res_next;
                        cout_q <= slice_cout;
                        idx    <= '0;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state == S_BUSY);
    assign bus.ack  = (state == S_DONE);
    assign bus.out  = out_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_int_add_seq.sv
// tb/tb_int_add_seq.sv - self-checking bench for int_add_seq (WIDTH=32, CHUNK=8)

module tb_int_add_seq;

    logic clk;
    logic rst;

    int_add_seq_if #(.WIDTH(32)) bus ();

    int_add_seq #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.req = 1'b1;
        bus.a   = a;
        bus.b   = b;
    endtask

    // Waits (bounded) for ack; lat counts falling edges until ack is seen,
    // nbusy counts falling edges with busy high before it. lat=-1 on timeout.
    task automatic wait_ack(input bit drop_req, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (drop_req) bus.req = 1'b0;
            if (bus.ack) begin
                lat = k;
                break;
            end
            if (bus.busy) nbusy++;
        end
    endtask

    initial begin
        int lat;
        int nb;
        int acks;
        int busy_seen;
        logic [31:0] held;
        logic [31:0] ack_out;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[1] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
        vecs[6] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

        rst     = 1'b1;
        bus.req = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
`ifdef INT_ADD_SEQ_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset ack",  64'(bus.ack),  64'd0);
        check("reset out",  64'(bus.out),  64'd0);
        check("reset cout", 64'(bus.cout), 64'd0);
        rst = 1'b0;

        // Table: latency, busy length, result, and hold in following IDLE cycles.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_ack(1'b1, lat, nb);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
            check($sformatf("vec%0d busy cycles", i), 64'(nb), 64'd4);
            check($sformatf("vec%0d out", i), 64'(bus.out), 64'(vecs[i].exp_out));
            check($sformatf("vec%0d cout", i), 64'(bus.cout), 64'(vecs[i].exp_cout));
            repeat (2) begin
                @(negedge clk);
                check($sformatf("vec%0d idle ack", i), 64'(bus.ack), 64'd0);
                check($sformatf("vec%0d idle busy", i), 64'(bus.busy), 64'd0);
                check($sformatf("vec%0d hold out", i), 64'(bus.out), 64'(vecs[i].exp_out));
            end
        end

        // Back-to-back with req held high: (1,2) then (3,4).
        start_op(32'd1, 32'd2);
        @(negedge clk);
        bus.a = 32'd3;
        bus.b = 32'd4;
        wait_ack(1'b0, lat, nb);
        check("b2b first latency", 64'(lat + 1), 64'd5);
        check("b2b first out", 64'(bus.out), 64'd3);
        wait_ack(1'b0, lat, nb);
        bus.req = 1'b0;
        check("b2b ack spacing", 64'(lat), 64'd5);
        check("b2b second busy", 64'(nb), 64'd4);
        check("b2b second out", 64'(bus.out), 64'd7);
        @(negedge clk);
        check("b2b then idle busy", 64'(bus.busy), 64'd0);
        check("b2b then idle ack", 64'(bus.ack), 64'd0);

        // req in the 2nd BUSY cycle is ignored.
        start_op(32'd10, 32'd20);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("in-flight busy", 64'(bus.busy), 64'd1);
        check("in-flight out held", 64'(bus.out), 64'd7);
        bus.req = 1'b1;
        bus.a   = 32'hAAAA_AAAA;
        bus.b   = 32'hAAAA_AAAA;
        @(negedge clk);
        bus.req = 1'b0;
        acks    = 0;
        ack_out = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                acks++;
                ack_out = bus.out;
            end
        end
        check("ignored req ack count", 64'(acks), 64'd1);
        check("ignored req out", 64'(ack_out), 64'd30);
        check("ignored req cout", 64'(bus.cout), 64'd0);

        // rst in the 3rd BUSY cycle aborts at once with no ack.
        start_op(32'd5, 32'd6);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-abort busy", 64'(bus.busy), 64'd1);
        held = bus.out;
        check("pre-abort out", 64'(held), 64'd30);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort out", 64'(bus.out), 64'd0);
        check("abort cout", 64'(bus.cout), 64'd0);
        check("abort ack", 64'(bus.ack), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        acks      = 0;
        busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.ack) acks++;
            if (bus.busy) busy_seen++;
        end
        check("post-abort acks", 64'(acks), 64'd0);
        check("post-abort busy", 64'(busy_seen), 64'd0);

`ifdef INT_ADD_SEQ_SUB_EN
        start_op(32'd5, 32'd7);
        bus.sub = 1'b1;
        wait_ack(1'b1, lat, nb);
        check("sub 5-7 out", 64'(bus.out), 64'hFFFF_FFFE);
        check("sub 5-7 cout", 64'(bus.cout), 64'd0);
        start_op(32'd7, 32'd5);
        wait_ack(1'b1, lat, nb);
        bus.sub = 1'b0;
        check("sub 7-5 out", 64'(bus.out), 64'd2);
        check("sub 7-5 cout", 64'(bus.cout), 64'd1);
        start_op(32'd7, 32'd5);
        wait_ack(1'b1, lat, nb);
        check("add after sub out", 64'(bus.out), 64'd12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
